// File: rtl/polyeval_pkg.sv
// Shared width helpers for the polynomial-evaluator result path.
// Storage entries carry {seq, data}; occupancy counters span 0..DEPTH inclusive.
package polyeval_pkg;

   function automatic int entry_w(input int wid_d, input int seq_w);
      return wid_d + seq_w;
   endfunction

   function automatic int occ_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/polyeval_out_buf_if.sv
// Result stream leaving the output buffer.
// Handshake: a beat transfers on a rising edge where m_vld_o && m_rdy_i; once m_vld_o is high, m_data_o/m_seq_o hold until that beat or a flush.
interface polyeval_out_buf_if #(
   parameter int WID_D = 32,
   parameter int SEQ_W = 8
);
   logic [WID_D-1:0] m_data_o;
   logic [SEQ_W-1:0] m_seq_o;
   logic             m_vld_o;
   logic             m_rdy_i;

   modport master (output m_data_o, m_seq_o, m_vld_o, input m_rdy_i);
   modport slave  (input m_data_o, m_seq_o, m_vld_o, output m_rdy_i);
endinterface

// File: rtl/polyeval_sync_fifo.sv
// First-word fall-through synchronous FIFO with flush.
// Flush beats push and pop; a push into a full FIFO is accepted only alongside a pop.
module polyeval_sync_fifo
   import polyeval_pkg::*;
#(
   parameter  int WID   = 40,
   parameter  int DEPTH = 16,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = occ_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             wr_req,
   input  logic [WID-1:0]   wr_data,
   input  logic             rd_rdy,
   output logic [WID-1:0]   rd_data,
   output logic             rd_vld,
   output logic             rd_ok,
   output logic             full,
   output logic [CNT_W-1:0] count
);

   logic [WID-1:0]   mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             wr_ok;

   assign rd_vld  = (count != '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign rd_ok   = rd_vld & rd_rdy;
   assign wr_ok   = wr_req & ~flush & (~full | rd_ok);
   assign rd_data = mem[rd_ptr];

   // Memory is deliberately not reset; pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/polyeval_out_buf.sv
// Result buffer behind the polynomial evaluator: absorbs non-stallable pushes,
// tags each arrival with a sequence number, and accounts for overflow losses.
module polyeval_out_buf
   import polyeval_pkg::*;
#(
   parameter  int WID_D    = 32,
   parameter  int DEPTH    = 16,
   parameter  int AFULL_TH = 12,
   parameter  int SEQ_W    = 8,
   parameter  int DROP_W   = 16,
   localparam int CNT_W    = occ_w(DEPTH),
   localparam int ENT_W    = entry_w(WID_D, SEQ_W)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [WID_D-1:0]    data_i,
   input  logic                data_vld_i,
   input  logic                flush_i,
   polyeval_out_buf_if.master  m,
   output logic [CNT_W-1:0]    count_o,
   output logic                afull_o,
   output logic                ovf_o,
   input  logic                ovf_clr_i,
   output logic [DROP_W-1:0]   drop_cnt_o
);

   logic [SEQ_W-1:0]  seq_cnt;
   logic [ENT_W-1:0]  head;
   logic              full;
   logic              pop;
   logic              drop;

   polyeval_sync_fifo #(
      .WID   (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush_i),
      .wr_req  (data_vld_i),
      .wr_data ({seq_cnt, data_i}),
      .rd_rdy  (m.m_rdy_i),
      .rd_data (head),
      .rd_vld  (m.m_vld_o),
      .rd_ok   (pop),
      .full    (full),
      .count   (count_o)
   );

   assign m.m_seq_o  = head[ENT_W-1:WID_D];
   assign m.m_data_o = head[WID_D-1:0];
   assign afull_o    = (count_o >= CNT_W'(AFULL_TH));

   // An arrival lost to flush is not an overflow; only a full FIFO without a pop drops.
   assign drop = data_vld_i & ~flush_i & full & ~pop;

   // Every arrival consumes a tag, so gaps downstream expose lost results.
   always_ff @(posedge clk) begin
      if (rst) begin
         seq_cnt <= '0;
      end else if (data_vld_i) begin
         seq_cnt <= seq_cnt + SEQ_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || ovf_clr_i) begin
         ovf_o      <= 1'b0;
         drop_cnt_o <= '0;
      end else if (drop) begin
         ovf_o <= 1'b1;
         if (drop_cnt_o != '1) begin
            drop_cnt_o <= drop_cnt_o + DROP_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_polyeval_out_buf.sv
// Directed bench for polyeval_out_buf: a vector table for short sequences plus
// hand-written runs for fill/overflow, full-rate streaming, sequence wrap and clear/reset.
module tb_polyeval_out_buf;

   localparam int WID_D = 32;
   localparam int SEQ_W = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] data;
   logic        data_vld;
   logic        flush;
   logic        clr;
   logic [4:0]  count;
   logic        afull;
   logic        ovf;
   logic [15:0] drop_cnt;

   int n_chk = 0;
   int n_err = 0;

   logic [WID_D+SEQ_W-1:0] exp_q[$];

   polyeval_out_buf_if #(.WID_D(WID_D), .SEQ_W(SEQ_W)) m_if ();

   polyeval_out_buf dut (
      .clk        (clk),
      .rst        (rst),
      .data_i     (data),
      .data_vld_i (data_vld),
      .flush_i    (flush),
      .m          (m_if),
      .count_o    (count),
      .afull_o    (afull),
      .ovf_o      (ovf),
      .ovf_clr_i  (clr),
      .drop_cnt_o (drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, vld, flush, rdy, clr;
      logic [31:0] data;
      logic [4:0]  e_cnt;
      logic        e_vld;
      logic [31:0] e_data;
      logic [7:0]  e_seq;
      logic        e_afull, e_ovf;
      logic [15:0] e_drop;
   } vec_t;

   vec_t vecs[15];

   function automatic vec_t mk(input logic r, input logic v, input logic f, input logic rd,
                               input logic [31:0] d, input logic [4:0] ec, input logic ev,
                               input logic [31:0] ed, input logic [7:0] es);
      vec_t t;
      t.rst = r; t.vld = v; t.flush = f; t.rdy = rd; t.clr = 1'b0; t.data = d;
      t.e_cnt = ec; t.e_vld = ev; t.e_data = ed; t.e_seq = es;
      t.e_afull = 1'b0; t.e_ovf = 1'b0; t.e_drop = '0;
      return t;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      rst = 1'b0; data_vld = 1'b0; flush = 1'b0; clr = 1'b0; data = '0;
      m_if.m_rdy_i = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic chk_head(input string name);
      chk(name, {m_if.m_vld_o, m_if.m_seq_o, m_if.m_data_o}, {1'b1, exp_q[0]});
      void'(exp_q.pop_front());
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("reset_count", count, 0);
      chk("reset_vld", m_if.m_vld_o, 0);
      chk("reset_flags", {afull, ovf, drop_cnt}, 0);

      // three pushes held, then drain; reset; five pushes, flush with coincident push, next push
      vecs[0]  = mk(0, 1, 0, 0, 32'h11, 1, 1, 32'h11, 0);
      vecs[1]  = mk(0, 1, 0, 0, 32'h22, 2, 1, 32'h11, 0);
      vecs[2]  = mk(0, 1, 0, 0, 32'h33, 3, 1, 32'h11, 0);
      vecs[3]  = mk(0, 0, 0, 1, 32'h0,  2, 1, 32'h22, 1);
      vecs[4]  = mk(0, 0, 0, 1, 32'h0,  1, 1, 32'h33, 2);
      vecs[5]  = mk(0, 0, 0, 1, 32'h0,  0, 0, 32'h0,  0);
      vecs[6]  = mk(1, 0, 0, 0, 32'h0,  0, 0, 32'h0,  0);
      vecs[7]  = mk(0, 1, 0, 0, 32'h100, 1, 1, 32'h100, 0);
      vecs[8]  = mk(0, 1, 0, 0, 32'h101, 2, 1, 32'h100, 0);
      vecs[9]  = mk(0, 1, 0, 0, 32'h102, 3, 1, 32'h100, 0);
      vecs[10] = mk(0, 1, 0, 0, 32'h103, 4, 1, 32'h100, 0);
      vecs[11] = mk(0, 1, 0, 0, 32'h104, 5, 1, 32'h100, 0);
      vecs[12] = mk(0, 1, 1, 0, 32'h55,  0, 0, 32'h0,   0);
      vecs[13] = mk(0, 1, 0, 0, 32'h66,  1, 1, 32'h66,  6);
      vecs[14] = mk(0, 0, 0, 1, 32'h0,   0, 0, 32'h0,   0);

      for (int i = 0; i < 15; i++) begin
         rst = vecs[i].rst; data_vld = vecs[i].vld; flush = vecs[i].flush;
         m_if.m_rdy_i = vecs[i].rdy; clr = vecs[i].clr; data = vecs[i].data;
         tick();
         chk($sformatf("vec%0d_count", i), count, vecs[i].e_cnt);
         chk($sformatf("vec%0d_vld", i), m_if.m_vld_o, vecs[i].e_vld);
         chk($sformatf("vec%0d_flags", i), {afull, ovf, drop_cnt},
             {vecs[i].e_afull, vecs[i].e_ovf, vecs[i].e_drop});
         if (vecs[i].e_vld) begin
            chk($sformatf("vec%0d_head", i), {m_if.m_seq_o, m_if.m_data_o},
                {vecs[i].e_seq, vecs[i].e_data});
         end
      end

      // fill past full with no reader: two drops, afull from the 12th entry
      do_reset();
      for (int k = 1; k <= 18; k++) begin
         data_vld = 1'b1;
         data = 32'h1000 + 32'(k - 1);
         tick();
         chk($sformatf("fill%0d_count", k), count, (k > 16) ? 16 : k);
         chk($sformatf("fill%0d_afull", k), afull, (k >= 12) ? 1 : 0);
      end
      data_vld = 1'b0;
      chk("fill_ovf", ovf, 1);
      chk("fill_drop", drop_cnt, 2);
      m_if.m_rdy_i = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("fill_drain%0d", i), {m_if.m_vld_o, m_if.m_seq_o, m_if.m_data_o},
             {1'b1, 8'(i), 32'h1000 + 32'(i)});
         tick();
      end
      chk("fill_empty", {m_if.m_vld_o, count}, 0);

      // full FIFO with push and pop every cycle: no drops, count pinned at 16
      do_reset();
      exp_q.delete();
      for (int i = 0; i < 16; i++) begin
         data_vld = 1'b1;
         data = 32'(i);
         exp_q.push_back({8'(i), 32'(i)});
         tick();
      end
      for (int j = 0; j < 10; j++) begin
         data_vld = 1'b1; data = 32'hAA; m_if.m_rdy_i = 1'b1;
         chk_head($sformatf("pp%0d_head", j));
         exp_q.push_back({8'(16 + j), 32'hAA});
         tick();
         chk($sformatf("pp%0d_count", j), count, 16);
         chk($sformatf("pp%0d_drop", j), {ovf, drop_cnt}, 0);
      end
      data_vld = 1'b0;
      for (int i = 0; i < 16; i++) begin
         chk_head($sformatf("pp_drain%0d", i));
         tick();
      end
      chk("pp_empty", {m_if.m_vld_o, count}, 0);

      // 300 results at full rate: sequence wraps 255 -> 0 with no gaps
      do_reset();
      m_if.m_rdy_i = 1'b1;
      for (int i = 0; i < 300; i++) begin
         data_vld = 1'b1;
         data = 32'h2000 + 32'(i);
         tick();
         chk($sformatf("stream%0d", i), {m_if.m_vld_o, m_if.m_seq_o, m_if.m_data_o},
             {1'b1, 8'(i), 32'h2000 + 32'(i)});
      end
      data_vld = 1'b0;
      tick();
      chk("stream_empty", {m_if.m_vld_o, count}, 0);

      // clear wins over a coincident drop; next drop records 1/1; reset mid-stream
      do_reset();
      for (int i = 0; i < 16; i++) begin
         data_vld = 1'b1;
         data = 32'h3000 + 32'(i);
         tick();
      end
      clr = 1'b1;
      tick();
      chk("clr_drop_flags", {ovf, drop_cnt}, 0);
      chk("clr_drop_count", count, 16);
      clr = 1'b0;
      tick();
      chk("drop_after_clr", {ovf, drop_cnt}, {1'b1, 16'd1});
      rst = 1'b1;
      tick();
      chk("midrst_outputs", {m_if.m_vld_o, count, afull, ovf, drop_cnt}, 0);
      rst = 1'b0;
      data = 32'h77;
      tick();
      chk("midrst_seq", {m_if.m_vld_o, m_if.m_seq_o, m_if.m_data_o}, {1'b1, 8'd0, 32'h77});
      idle_inputs();
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/polyeval_out_buf.md
# polyeval_out_buf

Result buffer directly downstream of the polynomial-evaluation top level. It captures every `data_cal_out` / `data_vld_o` push, which cannot be back-pressured, into a FIFO and re-issues each result on a valid/ready stream tagged with an arrival sequence number. It also raises an almost-full hint so the input source can throttle, and records overflow losses instead of stalling.

## Interface
- `WID_D`, 32, result data width; matches the evaluator output width.
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2.
- `AFULL_TH`, 12, occupancy at or above which `afull_o` asserts; 1..DEPTH.
- `SEQ_W`, 8, sequence-tag width.
- `DROP_W`, 16, drop-counter width.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `data_i`  in  WID_D  evaluator result (`data_cal_out`).
- `data_vld_i`  in  1  result strobe (`data_vld_o`); one result per cycle while high.
- `flush_i`  in  1  discard all stored entries.
- `m_data_o`  out  WID_D  head-of-FIFO result.
- `m_seq_o`  out  SEQ_W  sequence tag of the head entry.
- `m_vld_o`  out  1  head entry valid.
- `m_rdy_i`  in  1  consumer ready.
- `count_o`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `afull_o`  out  1  `count_o >= AFULL_TH`.
- `ovf_o`  out  1  sticky overflow flag.
- `ovf_clr_i`  in  1  clear `ovf_o` and `drop_cnt_o`.
- `drop_cnt_o`  out  DROP_W  saturating count of results lost to a full FIFO.

## Operation
- Storage is a DEPTH × (WID_D + SEQ_W) register array, with `wr_ptr` / `rd_ptr` of $clog2(DEPTH) bits and a separate occupancy counter.
- Pointers wrap modulo DEPTH.
- Output is first-word fall-through:
  - `m_data_o` / `m_seq_o` = `mem[rd_ptr]`.
  - `m_vld_o` = (`count_o != 0`).
- Pop: `m_vld_o && m_rdy_i` advances `rd_ptr` and decrements the count.
- Push: `data_vld_i` writes {`seq_cnt`, `data_i`} at `wr_ptr` when `count_o < DEPTH`, or when `count_o == DEPTH` and a pop happens in the same cycle.
- Simultaneous push and pop leaves the count unchanged and never drops, even at full.
- Sequence tag: `seq_cnt` increments on every `data_vld_i` cycle, including dropped and flushed arrivals. It wraps 2^SEQ_W−1 → 0. A gap in `m_seq_o` therefore marks lost results.
- Drop: `data_vld_i` while full with no pop:
  - the sample is discarded;
  - `ovf_o` is set;
  - `drop_cnt_o` increments and saturates at 2^DROP_W−1.
- Flush: `flush_i` zeroes the pointers and count on the next edge.
  - Flush has priority over push and pop in the same cycle. The concurrent arrival is lost but does not count as a drop.
  - `seq_cnt`, `ovf_o` and `drop_cnt_o` are unaffected.
- Clear: `ovf_clr_i` zeroes `ovf_o` and `drop_cnt_o`. If a drop occurs in the same cycle, clear wins and the drop is not recorded.
- Once `m_vld_o` is high, the consumer contract holds: head data is stable until popped or flushed.

## Timing
- Reset (`rst` high at an edge):
  - pointers, count and `seq_cnt` = 0;
  - `m_vld_o` = 0, `afull_o` = 0, `ovf_o` = 0, `drop_cnt_o` = 0, `count_o` = 0;
  - `m_seq_o` / `m_data_o` are don't-care while `m_vld_o` = 0.
- Reset mid-operation discards all contents with no drain. The memory array is not reset.
- Latency is 1 cycle: a push at edge N with an empty FIFO gives `m_vld_o` = 1 after edge N.
- There is no bypass. A push and a consumer waiting on an empty FIFO cannot complete in the same cycle.
- `count_o`, `afull_o`, `ovf_o` and `drop_cnt_o` are registered and reflect the state after the last edge.
- Throughput is one push plus one pop per cycle, sustained.

## Structure
- A shared `polyeval_pkg` holds:
  - the entry width helper (WID_D + SEQ_W);
  - the occupancy-width function $clog2(DEPTH)+1, which is reused by the top level for `count_o` wiring.
- One sub-module is natural: `polyeval_sync_fifo`, which holds storage, pointers, count, push/pop/flush priority and FWFT read.
  - The wrapper adds sequence tagging, drop and overflow accounting, and `afull_o`.

## Test plan
- Reset, then 3 pushes (0x11, 0x22, 0x33) with `m_rdy_i` = 0 → `count_o` = 3, head 0x11 / seq 0; then `m_rdy_i` = 1 → 0x11, 0x22, 0x33 with seq 0, 1, 2 on consecutive cycles; `m_vld_o` falls after the third.
- DEPTH = 16, 18 back-to-back pushes, no reads → `count_o` = 16, `afull_o` high from the 12th push, `ovf_o` = 1, `drop_cnt_o` = 2; drain yields seq 0..15.
- Full FIFO with simultaneous push (0xAA) and pop every cycle for 10 cycles → `count_o` stays 16, `drop_cnt_o` unchanged, 0xAA appears in order.
- 300 pushes with continuous ready, SEQ_W = 8 → `m_seq_o` wraps 255 → 0 at result 256, with no gaps.
- `flush_i` with 5 entries stored and push 0x55 in the same cycle → next cycle `count_o` = 0, `m_vld_o` = 0; the next push carries seq 6.
- `ovf_clr_i` coincident with a drop → `ovf_o` = 0, `drop_cnt_o` = 0; a following drop sets 1 / 1. Assert `rst` mid-stream → all outputs return to reset values on the next edge.
